regfile_bypass: RTL and testbench

Parametrised successor to the pipeline CPU's general-purpose register file. It is built around a multi-register array with a hardwired zero register and a programmable stack-pointer reset value. It adds three things to the existing 2R/1W file:
- same-cycle write-to-read bypass, so the writeback stage feeds decode directly;
- a per-register pending scoreboard for hazard detection;
- clocked writes with an asynchronous, active-low reset.

It sits between the decode and writeback stages of the pipeline.

---
 rtl/regfile_bypass.sv | 87 ++++++++
 tb/tb_regfile_bypass.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// General-purpose register file: 2 read / 1 write ports, hardwired zero register,
// programmable stack-pointer reset, same-cycle write bypass and a pending scoreboard.
module regfile_bypass #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'h0000_0400,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned DBG_A    = 16,
  parameter int unsigned DBG_B    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  output logic              busy1,
  output logic              busy2,
  output logic [7:0]        dbg_a,
  output logic [7:0]        dbg_b
);

  localparam int unsigned       NREG     = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] SP_RST_V = DATA_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] LP_DBG_A = ADDR_W'(DBG_A);
  localparam logic [ADDR_W-1:0] LP_DBG_B = ADDR_W'(DBG_B);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;

  logic w_wr_en;
  logic w_iss_en;
  logic w_hit1;
  logic w_hit2;

  assign w_wr_en  = we && (wa != '0);
  assign w_iss_en = iss_valid && (iss_reg != '0);

  // Issue is applied after writeback so a same-edge collision leaves the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? SP_RST_V : '0;
      end
      r_pend <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[wa] <= wd;
        r_pend[wa] <= 1'b0;
      end
      if (w_iss_en) begin
        r_pend[iss_reg] <= 1'b1;
      end
    end
  end

  assign w_hit1 = BYPASS && we && (wa == ra1) && (ra1 != '0);
  assign w_hit2 = BYPASS && we && (wa == ra2) && (ra2 != '0);

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = w_hit1 ? wd : r_regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = w_hit2 ? wd : r_regs[ra2];
    end
  end

  // Pending bit 0 is never set, so register 0 is never busy.
  assign busy1 = r_pend[ra1] && !w_hit1;
  assign busy2 = r_pend[ra2] && !w_hit2;

  assign dbg_a = r_regs[LP_DBG_A][7:0];
  assign dbg_b = r_regs[LP_DBG_B][7:0];

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: BYPASS=1 and BYPASS=0 instances driven in parallel,
// checked every cycle against an array model plus directed literal expectations.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, iss_reg;
  logic        we, iss_valid;
  logic [31:0] wd;

  logic [31:0] rd1_1, rd2_1, rd1_0, rd2_0;
  logic        busy1_1, busy2_1, busy1_0, busy2_0;
  logic [7:0]  dbga_1, dbgb_1, dbga_0, dbgb_0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_bypass #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_reg(iss_reg),
    .busy1(busy1_1), .busy2(busy2_1), .dbg_a(dbga_1), .dbg_b(dbgb_1)
  );

  regfile_bypass #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_reg(iss_reg),
    .busy1(busy1_0), .busy2(busy2_0), .dbg_a(dbga_0), .dbg_b(dbgb_0)
  );

  // Reference model: plain array of register values and a pending flag per register.
  logic [31:0] m_reg [32];
  bit          m_pend [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = (i == 29) ? 32'h0000_0400 : 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      if (we && wa != 5'd0) begin
        m_reg[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (iss_valid && iss_reg != 5'd0) m_pend[iss_reg] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && we && wa == ra) return wd;
    return m_reg[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 1'b0;
    return m_pend[ra] && !(byp && we && wa == ra);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_dut(input string tag, input bit byp,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic b1, input logic b2,
                         input logic [7:0] da, input logic [7:0] db);
    chk({tag, ".rd1"},   r1, exp_rd(ra1, byp));
    chk({tag, ".rd2"},   r2, exp_rd(ra2, byp));
    chk({tag, ".busy1"}, {31'h0, b1}, {31'h0, exp_busy(ra1, byp)});
    chk({tag, ".busy2"}, {31'h0, b2}, {31'h0, exp_busy(ra2, byp)});
    chk({tag, ".dbg_a"}, {24'h0, da}, {24'h0, m_reg[16][7:0]});
    chk({tag, ".dbg_b"}, {24'h0, db}, {24'h0, m_reg[17][7:0]});
  endtask

  always @(negedge clk) begin
    cmp_dut("byp1", 1'b1, rd1_1, rd2_1, busy1_1, busy2_1, dbga_1, dbgb_1);
    cmp_dut("byp0", 1'b0, rd1_0, rd2_0, busy1_0, busy2_0, dbga_0, dbgb_0);
  end

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic iv, input logic [4:0] ir,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    we = w; wa = a; wd = d; iss_valid = iv; iss_reg = ir; ra1 = r1; ra2 = r2;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_reg = '0; ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset pulse between edges
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd29, 5'd5);
    reset = 1'b0;
    #1;
    chk("rst.rd1_sp", rd1_1, 32'h0000_0400);
    chk("rst.rd2_r5", rd2_1, 32'h0);
    chk("rst.busy1",  {31'h0, busy1_1}, 32'h0);
    chk("rst.busy2",  {31'h0, busy2_1}, 32'h0);
    reset = 1'b1;

    // Write / read, write to r0 ignored
    cyc(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd3, 5'd0);
    cyc(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("wr.rd1_b0", rd1_0, 32'hDEAD_BEEF);
    chk("wr.rd1_b1", rd1_1, 32'hDEAD_BEEF);
    chk("wr0.rd2_b1", rd2_1, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("wr0.rd2_after", rd2_0, 32'h0);

    // Bypass
    cyc(1'b1, 5'd7, 32'hCAFE_0001, 1'b0, 5'd0, 5'd7, 5'd3);
    chk("byp.rd1_b1", rd1_1, 32'hCAFE_0001);
    chk("byp.rd1_b0_old", rd1_0, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    chk("byp.rd1_b0_new", rd1_0, 32'hCAFE_0001);
    chk("byp.rd2_b1_new", rd2_1, 32'hCAFE_0001);

    // Scoreboard set / clear
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    chk("sb.busy_pre", {31'h0, busy1_1}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("sb.busy1_b1", {31'h0, busy1_1}, 32'h1);
    chk("sb.busy2_b0", {31'h0, busy2_0}, 32'h1);
    cyc(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("sb.wb_busy1_b1", {31'h0, busy1_1}, 32'h0);
    chk("sb.wb_busy1_b0", {31'h0, busy1_0}, 32'h1);
    chk("sb.wb_rd1_b1", rd1_1, 32'h0000_0099);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("sb.clr_busy1_b0", {31'h0, busy1_0}, 32'h0);
    chk("sb.clr_rd1_b0", rd1_0, 32'h0000_0099);

    // Set-wins collision
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    cyc(1'b1, 5'd9, 32'h5555_AAAA, 1'b1, 5'd9, 5'd9, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("col.busy1_b1", {31'h0, busy1_1}, 32'h1);
    chk("col.busy1_b0", {31'h0, busy1_0}, 32'h1);
    chk("col.rd1_b0", rd1_0, 32'h5555_AAAA);

    // Debug outputs, then reset between edges
    cyc(1'b1, 5'd16, 32'h0000_00A5, 1'b1, 5'd20, 5'd9, 5'd20);
    cyc(1'b1, 5'd17, 32'h1234_5677, 1'b0, 5'd0, 5'd9, 5'd20);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd20);
    chk("dbg.a_b1", {24'h0, dbga_1}, 32'hA5);
    chk("dbg.b_b0", {24'h0, dbgb_0}, 32'h77);
    chk("dbg.busy2_r20", {31'h0, busy2_1}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mrst.dbg_a", {24'h0, dbga_1}, 32'h0);
    chk("mrst.dbg_b", {24'h0, dbgb_0}, 32'h0);
    chk("mrst.busy1", {31'h0, busy1_1}, 32'h0);
    chk("mrst.busy2", {31'h0, busy2_0}, 32'h0);
    chk("mrst.rd1_r9", rd1_0, 32'h0);

    // Writes and issues while reset is held are ignored
    cyc(1'b1, 5'd5, 32'h0BAD_F00D, 1'b1, 5'd5, 5'd5, 5'd29);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd29);
    reset = 1'b1;
    #1;
    chk("hold.rd1_r5", rd1_1, 32'h0);
    chk("hold.busy1", {31'h0, busy1_0}, 32'h0);
    chk("hold.rd2_sp", rd2_0, 32'h0000_0400);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd29);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
